// File: rtl/fpnew_pkg.sv
// Minimal excerpt of the FPnew package: only the IEEE status flag bundle used by
// the result buffer. The bit order {NV,DZ,OF,UF,NX} matches the fflags CSR layout.
package fpnew_pkg;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

endpackage

// File: rtl/fpu_resbuf_pkg.sv
// Shared types for the FPU result buffer: the buffered entry layout and the
// accrued-flags width.
package fpu_resbuf_pkg;

  localparam int unsigned FFLAGS_W = 5;
  localparam int unsigned RESULT_W = 64;
  localparam int unsigned TAG_W    = 5;

  typedef struct packed {
    logic [RESULT_W-1:0] result;
    fpnew_pkg::status_t  status;
    logic [TAG_W-1:0]    tag;
  } entry_t;

endpackage

// File: rtl/fpu_fflags_acc.sv
// Sticky accrued-exception register: ORs in the status of each retired result;
// a clear racing a retire leaves only the retiring status.
module fpu_fflags_acc
  import fpu_resbuf_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                acc_i,
  input  logic                clr_i,
  input  logic [FFLAGS_W-1:0] status_i,
  output logic [FFLAGS_W-1:0] fflags_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fflags_o <= '0;
    end else if (acc_i && clr_i) begin
      fflags_o <= status_i;
    end else if (acc_i) begin
      fflags_o <= fflags_o | status_i;
    end else if (clr_i) begin
      fflags_o <= '0;
    end
  end

endmodule

// File: rtl/fpu_result_buffer.sv
// Circular result FIFO between the FPU and writeback, with sticky fflags and
// overflow tracking. Define FPU_RESULT_BYPASS_EN for the empty-buffer bypass path.
module fpu_result_buffer
  import fpu_resbuf_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned WIDTH     = RESULT_W,
  parameter int unsigned TAG_WIDTH = TAG_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  input  logic [WIDTH-1:0]     in_result_i,
  input  fpnew_pkg::status_t   in_status_i,
  input  logic [TAG_WIDTH-1:0] in_tag_i,
  output logic                 in_ready_o,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [WIDTH-1:0]     wb_result_o,
  output fpnew_pkg::status_t   wb_status_o,
  output logic [TAG_WIDTH-1:0] wb_tag_o,
  output logic [FFLAGS_W-1:0]  fflags_o,
  input  logic                 fflags_clr_i,
  output logic                 overflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;

  logic   fifo_empty, fifo_full;
  logic   pop_fifo, push, drop, accrue, push_block;
  entry_t in_entry, head, wb_entry;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign in_ready_o = !fifo_full;

  assign in_entry = '{result: RESULT_W'(in_result_i),
                      status: in_status_i,
                      tag:    TAG_W'(in_tag_i)};
  assign head     = mem[rd_ptr];

`ifdef FPU_RESULT_BYPASS_EN
  logic bypass;
  assign bypass     = in_valid_i && fifo_empty;
  assign wb_valid_o = !fifo_empty || bypass;
  assign wb_entry   = bypass ? in_entry : head;
  // A bypassed result taken by writeback this cycle never enters storage.
  assign push_block = bypass && wb_ready_i;
`else
  assign wb_valid_o = !fifo_empty;
  assign wb_entry   = head;
  assign push_block = 1'b0;
`endif

  assign wb_result_o = WIDTH'(wb_entry.result);
  assign wb_status_o = wb_entry.status;
  assign wb_tag_o    = TAG_WIDTH'(wb_entry.tag);

  always_comb begin
    pop_fifo = !fifo_empty && wb_ready_i;
    push     = in_valid_i && !push_block && (!fifo_full || pop_fifo);
    drop     = in_valid_i && fifo_full && !pop_fifo;
    accrue   = wb_valid_o && wb_ready_i && !flush_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (drop && !flush_i) overflow_o <= 1'b1;
      if (flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)     wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_fifo) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop_fifo})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush_i && !rst_i) mem[wr_ptr] <= in_entry;
  end

  fpu_fflags_acc u_fflags_acc (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .acc_i    (accrue),
    .clr_i    (fflags_clr_i),
    .status_i (wb_status_o),
    .fflags_o (fflags_o)
  );

endmodule

// File: doc/fpu_result_buffer.md
FPU_RESULT_BUFFER -- requirements
Module: fpu_result_buffer

Interface
REQ-001 Parameter: DEPTH, 4, number of result entries; a power of two, at least 2.
REQ-002 Parameter: WIDTH, 64, result width in bits.
REQ-003 Parameter: TAG_WIDTH, 5, writeback tag width in bits.
REQ-004 Port: clk_i  input  1  single clock, rising edge.
REQ-005 Port: rst_i  input  1  reset; synchronous, active-high.
REQ-006 Port: flush_i  input  1  discard all buffered results.
REQ-007 Port: in_valid_i  input  1  FPU result valid; a single-cycle pulse that cannot be stalled.
REQ-008 Port: in_result_i  input  WIDTH  FPU result.
REQ-009 Port: in_status_i  input  5  FPU flags {NV,DZ,OF,UF,NX}, typed fpnew_pkg::status_t.
REQ-010 Port: in_tag_i  input  TAG_WIDTH  FPU tag.
REQ-011 Port: in_ready_o  output  1  buffer not full; drives the FPU out_ready.
REQ-012 Port: wb_valid_o  output  1  head entry valid toward writeback.
REQ-013 Port: wb_ready_i  input  1  writeback accepts the head entry.
REQ-014 Port: wb_result_o / wb_status_o / wb_tag_o  output  WIDTH / 5 / TAG_WIDTH  head entry fields.
REQ-015 Port: fflags_o  output  5  accrued exception flags (sticky OR).
REQ-016 Port: fflags_clr_i  input  1  clear the accrued flags (CSR write).
REQ-017 Port: overflow_o  output  1  sticky: a result was dropped.

Function
REQ-018 Storage SHALL be a circular FIFO with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count of $clog2(DEPTH)+1 bits.
REQ-019 Push SHALL be in_valid_i && (count<DEPTH || pop), where pop is wb_valid_o && wb_ready_i.
REQ-020 Full with push and pop in the same cycle: both SHALL occur, count unchanged, pointers both advance.
REQ-021 in_ready_o SHALL be (count<DEPTH), registered-state only, with no combinational path from wb_ready_i.
REQ-022 in_valid_i while full without a pop: the entry SHALL be dropped and overflow_o set; it stays set until reset.
REQ-023 wb_valid_o SHALL be (count!=0); the wb_* outputs SHALL show the head entry.
REQ-024 Latency: a result pushed in cycle N SHALL appear on wb_* in cycle N+1 when the buffer was empty (see REQ-032 for the bypass exception).
REQ-025 wb_* outputs SHALL hold stable while wb_valid_o && !wb_ready_i.
REQ-026 fflags_o SHALL update on pop only: fflags_o <= fflags_o | wb_status_o.
REQ-027 fflags_clr_i and a pop in the same cycle: fflags_o SHALL become the popped wb_status_o only.
REQ-028 flush_i SHALL zero the pointers and count, and SHALL override push and pop in that cycle; the pop does not accrue fflags; fflags_o and overflow_o are kept.
REQ-029 Order: results SHALL leave in push order; tags SHALL not be reordered.

Reset
REQ-030 With rst_i high at a clock edge, the next cycle SHALL show: pointers 0, count 0, wb_valid_o 0, in_ready_o 1, fflags_o 0, overflow_o 0.
REQ-031 Reset SHALL win over flush_i, push and pop; entry contents are not reset.

Configuration
REQ-032 With FPU_RESULT_BYPASS_EN defined:
- When count==0 and in_valid_i, the in_* fields SHALL drive wb_* combinationally in the same cycle with wb_valid_o high.
- If wb_ready_i is also high, the entry SHALL not be stored, and fflags SHALL accrue as for a pop.
- If wb_ready_i is low, the entry SHALL be stored as a normal push.
REQ-033 Without FPU_RESULT_BYPASS_EN: no combinational in->wb path; REQ-024 latency applies.

Structure
REQ-034 Package fpu_resbuf_pkg SHALL hold the entry struct {result, status, tag} and FFLAGS_W=5; status_t comes from fpnew_pkg.
REQ-035 Sub-module fpu_fflags_acc SHALL hold the sticky OR/clear register; the FIFO logic stays inline.

Verification
REQ-036 Single push: reset, then push result 0x3FF0000000000000, tag 3, status NX, with wb_ready_i=1 -> wb_valid_o=1 next cycle with the same data; fflags_o=5'b00001 one cycle after the pop.
REQ-037 Fill then drop: push 4 tags (1..4) with wb_ready_i=0 -> in_ready_o=0; a 5th push sets overflow_o=1; raising wb_ready_i drains tags 1,2,3,4 in order.
REQ-038 Full push+pop: full buffer, push tag 7 while popping -> count stays 4, overflow_o stays 0, tag 7 is the last to drain.
REQ-039 Flush mid-drain: 3 entries (status DZ, NV, OF), pop one then assert flush_i -> wb_valid_o=0 next cycle; fflags_o=DZ only.
REQ-040 Clear race: fflags_o=NV, then fflags_clr_i together with a pop of a UF entry -> fflags_o=UF.
REQ-041 Bypass (FPU_RESULT_BYPASS_EN): empty buffer, in_valid_i with wb_ready_i=1 -> wb_valid_o=1 in the same cycle and count stays 0; without the macro, wb_valid_o rises one cycle later.
